// File: rtl/mem_access_pkg.sv
// Shared access-size encodings and lane helpers for the data-memory stage.
package mem_access_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   function automatic logic [3:0] f_be(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      case (size)
         MEM_BYTE: f_be = 4'b0001 << lo;
         MEM_HALF: f_be = 4'b0011 << lo;
         default:  f_be = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] f_wdata(
      input logic [1:0]  size,
      input logic [31:0] d
   );
      case (size)
         MEM_BYTE: f_wdata = {4{d[7:0]}};
         MEM_HALF: f_wdata = {2{d[15:0]}};
         default:  f_wdata = d;
      endcase
   endfunction

   function automatic logic f_misaligned(
      input logic [1:0] size,
      input logic [1:0] lo
   );
      case (size)
         MEM_BYTE: f_misaligned = 1'b0;
         MEM_HALF: f_misaligned = lo[0];
         default:  f_misaligned = |lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select with sign or zero extension.
module load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lo,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [31:0] w_shift;

   assign w_shift = rdata >> {lo, 3'b000};

   always_comb begin
      data = rdata;
      case (size)
         MEM_BYTE: data = {{24{~uns & w_shift[7]}}, w_shift[7:0]};
         MEM_HALF: data = {{16{~uns & w_shift[15]}}, w_shift[15:0]};
         default:  data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one data-memory request per op and
// returns a registered writeback pulse, with misalign and timeout faults.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] alu_result,
   input  logic        mem_to_reg_in,
   input  logic [1:0]  bytes_in,
   input  logic [31:0] wdata_in,
   input  logic        we_in,
   input  logic        re_in,
   input  logic [4:0]  rd_in,
   input  logic        reg_we_in,
   input  logic        unsigned_flag_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall_out,
   output logic        run_out,
   output logic [4:0]  rd_out,
   output logic        reg_we_out,
   output logic [31:0] wb_data,
   output logic        misaligned,
   output logic        bus_error
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {
      S_IDLE,
      S_REQ
   } state_t;

   state_t          r_state, w_state_nx;
   logic [CW-1:0]   r_cnt, w_cnt_nx;

   logic [1:0]  r_size, w_size_nx;
   logic [1:0]  r_lo, w_lo_nx;
   logic        r_uns, w_uns_nx;
   logic        r_st, w_st_nx;
   logic        r_rwe, w_rwe_nx;

   logic        w_req_nx, w_we_nx, w_stall_nx;
   logic [31:0] w_addr_nx, w_wdata_nx, w_wb_nx;
   logic [3:0]  w_be_nx;
   logic        w_run_nx, w_rwe_out_nx;
   logic [4:0]  w_rd_nx;
   logic        w_mis_nx, w_berr_nx;

   logic        w_cap, w_mem, w_mis;
   logic [31:0] w_ld;

   // Writeback source is implied by re_in; mem_to_reg_in is informational.
   logic        w_unused;
   assign w_unused = mem_to_reg_in;

   assign w_cap = run & (r_state == S_IDLE) & ~stall_out;
   assign w_mem = we_in | re_in;
   assign w_mis = f_misaligned(bytes_in, alu_result[1:0]);

   load_align u_align (
      .rdata (dmem_rdata),
      .lo    (r_lo),
      .size  (r_size),
      .uns   (r_uns),
      .data  (w_ld)
   );

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_size_nx    = r_size;
      w_lo_nx      = r_lo;
      w_uns_nx     = r_uns;
      w_st_nx      = r_st;
      w_rwe_nx     = r_rwe;
      w_req_nx     = dmem_req;
      w_we_nx      = dmem_we;
      w_addr_nx    = dmem_addr;
      w_be_nx      = dmem_be;
      w_wdata_nx   = dmem_wdata;
      w_stall_nx   = stall_out;
      w_wb_nx      = wb_data;
      w_rd_nx      = rd_out;
      w_run_nx     = 1'b0;
      w_rwe_out_nx = 1'b0;
      w_mis_nx     = 1'b0;
      w_berr_nx    = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (w_cap) begin
               w_rd_nx = rd_in;
               if (!w_mem) begin
                  w_run_nx     = 1'b1;
                  w_wb_nx      = alu_result;
                  w_rwe_out_nx = reg_we_in;
               end else if (w_mis) begin
                  w_run_nx = 1'b1;
                  w_mis_nx = 1'b1;
                  w_wb_nx  = alu_result;
               end else begin
                  w_state_nx = S_REQ;
                  w_cnt_nx   = CW'(1);
                  w_req_nx   = 1'b1;
                  w_stall_nx = 1'b1;
                  w_we_nx    = we_in;
                  w_addr_nx  = {alu_result[31:2], 2'b00};
                  w_be_nx    = f_be(bytes_in, alu_result[1:0]);
                  w_wdata_nx = f_wdata(bytes_in, wdata_in);
                  w_size_nx  = bytes_in;
                  w_lo_nx    = alu_result[1:0];
                  w_uns_nx   = unsigned_flag_in;
                  w_st_nx    = we_in;
                  w_rwe_nx   = reg_we_in & ~we_in;
               end
            end
         end
         S_REQ: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (dmem_ack || (r_cnt == CW'(TIMEOUT))) begin
               w_state_nx = S_IDLE;
               w_cnt_nx   = '0;
               w_req_nx   = 1'b0;
               w_we_nx    = 1'b0;
               w_addr_nx  = '0;
               w_be_nx    = '0;
               w_wdata_nx = '0;
               w_stall_nx = 1'b0;
               w_run_nx   = 1'b1;
               if (dmem_ack) begin
                  w_rwe_out_nx = r_rwe;
                  if (!r_st) w_wb_nx = w_ld;
               end else begin
                  w_berr_nx = 1'b1;
               end
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_size     <= '0;
         r_lo       <= '0;
         r_uns      <= 1'b0;
         r_st       <= 1'b0;
         r_rwe      <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         stall_out  <= 1'b0;
         run_out    <= 1'b0;
         rd_out     <= '0;
         reg_we_out <= 1'b0;
         wb_data    <= '0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_cnt      <= w_cnt_nx;
         r_size     <= w_size_nx;
         r_lo       <= w_lo_nx;
         r_uns      <= w_uns_nx;
         r_st       <= w_st_nx;
         r_rwe      <= w_rwe_nx;
         dmem_req   <= w_req_nx;
         dmem_we    <= w_we_nx;
         dmem_addr  <= w_addr_nx;
         dmem_be    <= w_be_nx;
         dmem_wdata <= w_wdata_nx;
         stall_out  <= w_stall_nx;
         run_out    <= w_run_nx;
         rd_out     <= w_rd_nx;
         reg_we_out <= w_rwe_out_nx;
         wb_data    <= w_wb_nx;
         misaligned <= w_mis_nx;
         bus_error  <= w_berr_nx;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus multi-cycle sequences.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic [31:0] alu_result = '0;
   logic        mem_to_reg_in = 1'b0;
   logic [1:0]  bytes_in = '0;
   logic [31:0] wdata_in = '0;
   logic        we_in = 1'b0;
   logic        re_in = 1'b0;
   logic [4:0]  rd_in = '0;
   logic        reg_we_in = 1'b0;
   logic        unsigned_flag_in = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        stall_out, run_out, reg_we_out;
   logic [4:0]  rd_out;
   logic [31:0] wb_data;
   logic        misaligned, bus_error;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .run(run),
      .alu_result(alu_result), .mem_to_reg_in(mem_to_reg_in),
      .bytes_in(bytes_in), .wdata_in(wdata_in),
      .we_in(we_in), .re_in(re_in), .rd_in(rd_in),
      .reg_we_in(reg_we_in), .unsigned_flag_in(unsigned_flag_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall_out(stall_out), .run_out(run_out), .rd_out(rd_out),
      .reg_we_out(reg_we_out), .wb_data(wb_data),
      .misaligned(misaligned), .bus_error(bus_error)
   );

   int n_tot = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      else
         n_pass++;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drop_in;
      run   = 1'b0;
      we_in = 1'b0;
      re_in = 1'b0;
   endtask

   task automatic pulse_end(input string nm);
      step();
      chk({nm, " run_out pulse"}, 32'(run_out), 32'd0);
   endtask

   task automatic mem_op(
      input string nm, input logic [31:0] addr,
      input logic we, input logic re, input logic [1:0] sz,
      input logic [31:0] wd, input logic uns,
      input logic [4:0] rd, input logic rwe,
      input logic [31:0] rdata, input int ack_at,
      input logic [3:0] e_be, input logic [31:0] e_wd,
      input logic [31:0] e_wb, input logic e_rwe,
      input logic e_berr, input int e_st
   );
      logic ok;
      int   nst;
      alu_result = addr; we_in = we; re_in = re; bytes_in = sz;
      wdata_in = wd; unsigned_flag_in = uns; rd_in = rd;
      reg_we_in = rwe; run = 1'b1;
      step();
      drop_in();
      chk({nm, " req"}, 32'(dmem_req), 32'd1);
      chk({nm, " we"}, 32'(dmem_we), 32'(we));
      chk({nm, " addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({nm, " be"}, 32'(dmem_be), 32'(e_be));
      if (we) chk({nm, " wdata"}, dmem_wdata, e_wd);
      ok  = 1'b1;
      nst = 0;
      for (int c = 0; c < 20 && stall_out; c++) begin
         nst++;
         ok &= (dmem_req === 1'b1) && (dmem_be === e_be) &&
               (dmem_addr === {addr[31:2], 2'b00});
         if (nst == ack_at) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
         end
         step();
         dmem_ack = 1'b0;
      end
      chk({nm, " held stable"}, 32'(ok), 32'd1);
      chk({nm, " stall cycles"}, nst, e_st);
      chk({nm, " run_out"}, 32'(run_out), 32'd1);
      chk({nm, " bus_error"}, 32'(bus_error), 32'(e_berr));
      chk({nm, " misaligned"}, 32'(misaligned), 32'd0);
      chk({nm, " reg_we_out"}, 32'(reg_we_out), 32'(e_rwe));
      chk({nm, " rd_out"}, 32'(rd_out), 32'(rd));
      chk({nm, " req dropped"}, 32'(dmem_req), 32'd0);
      chk({nm, " stall clear"}, 32'(stall_out), 32'd0);
      if (!we && !e_berr) chk({nm, " wb_data"}, wb_data, e_wb);
   endtask

   typedef struct {
      string       nm;
      logic [31:0] alu;
      logic        we;
      logic        re;
      logic [1:0]  sz;
      logic [4:0]  rd;
      logic        rwe;
      logic        chk_wb;
      logic [31:0] e_wb;
      logic        e_rwe;
      logic        e_mis;
   } vec_t;

   vec_t tv[6];

   initial begin
      logic seen;
      tv[0] = '{"add", 32'h0000_1234, 0, 0, 2'b10, 5'd5, 1, 1,
                32'h0000_1234, 1, 0};
      tv[1] = '{"alu_nowe", 32'hDEAD_BEEF, 0, 0, 2'b00, 5'd31, 0, 1,
                32'hDEAD_BEEF, 0, 0};
      tv[2] = '{"lw_101", 32'h0000_0101, 0, 1, 2'b10, 5'd9, 1, 0,
                32'h0, 0, 1};
      tv[3] = '{"sh_203", 32'h0000_0203, 1, 0, 2'b01, 5'd2, 1, 0,
                32'h0, 0, 1};
      tv[4] = '{"lh_105", 32'h0000_0105, 0, 1, 2'b01, 5'd4, 1, 0,
                32'h0, 0, 1};
      tv[5] = '{"l11_102", 32'h0000_0102, 0, 1, 2'b11, 5'd6, 1, 0,
                32'h0, 0, 1};

      #3;
      chk("rst dmem_req", 32'(dmem_req), 32'd0);
      chk("rst stall", 32'(stall_out), 32'd0);
      chk("rst run_out", 32'(run_out), 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst be", 32'(dmem_be), 32'd0);
      chk("rst faults", 32'({misaligned, bus_error}), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      for (int i = 0; i < 6; i++) begin
         alu_result = tv[i].alu; we_in = tv[i].we; re_in = tv[i].re;
         bytes_in = tv[i].sz; rd_in = tv[i].rd;
         reg_we_in = tv[i].rwe; run = 1'b1;
         step();
         drop_in();
         chk({tv[i].nm, " run_out"}, 32'(run_out), 32'd1);
         chk({tv[i].nm, " misaligned"}, 32'(misaligned), 32'(tv[i].e_mis));
         chk({tv[i].nm, " reg_we_out"}, 32'(reg_we_out), 32'(tv[i].e_rwe));
         chk({tv[i].nm, " rd_out"}, 32'(rd_out), 32'(tv[i].rd));
         chk({tv[i].nm, " no req"}, 32'(dmem_req), 32'd0);
         chk({tv[i].nm, " no stall"}, 32'(stall_out), 32'd0);
         if (tv[i].chk_wb) chk({tv[i].nm, " wb_data"}, wb_data, tv[i].e_wb);
         pulse_end(tv[i].nm);
      end

      // ack lands on the timeout cycle and must win
      mem_op("lb_103", 32'h103, 0, 1, 2'b00, 32'h0, 0, 5'd7, 1,
             32'h8012_3456, 4, 4'b1000, 32'h0, 32'hFFFF_FF80, 1, 0, 4);
      pulse_end("lb_103");
      mem_op("lbu_101", 32'h101, 0, 1, 2'b00, 32'h0, 1, 5'd8, 1,
             32'h0000_A500, 2, 4'b0010, 32'h0, 32'h0000_00A5, 1, 0, 2);
      pulse_end("lbu_101");
      mem_op("sh_202", 32'h202, 1, 0, 2'b01, 32'h1234_BEEF, 0, 5'd3, 1,
             32'h0, 2, 4'b1100, 32'hBEEF_BEEF, 32'h0, 0, 0, 2);
      pulse_end("sh_202");
      mem_op("lh_102", 32'h102, 0, 1, 2'b01, 32'h0, 0, 5'd10, 1,
             32'h8001_7FFF, 1, 4'b1100, 32'h0, 32'hFFFF_8001, 1, 0, 1);
      pulse_end("lh_102");
      mem_op("lw_200", 32'h200, 0, 1, 2'b10, 32'h0, 1, 5'd11, 1,
             32'hCAFE_F00D, 3, 4'b1111, 32'h0, 32'hCAFE_F00D, 1, 0, 3);
      pulse_end("lw_200");
      mem_op("sb_301", 32'h301, 1, 0, 2'b00, 32'h1234_56AB, 0, 5'd12, 1,
             32'h0, 1, 4'b0010, 32'hABAB_ABAB, 32'h0, 0, 0, 1);
      pulse_end("sb_301");
      mem_op("werew_400", 32'h400, 1, 1, 2'b11, 32'h1122_3344, 0, 5'd13, 1,
             32'h0, 1, 4'b1111, 32'h1122_3344, 32'h0, 0, 0, 1);

      // new op captured in the completion cycle
      alu_result = 32'h55; rd_in = 5'd3; reg_we_in = 1'b1; run = 1'b1;
      step();
      drop_in();
      chk("b2b run_out", 32'(run_out), 32'd1);
      chk("b2b wb_data", wb_data, 32'h55);
      pulse_end("b2b");

      mem_op("timeout", 32'h500, 0, 1, 2'b10, 32'h0, 0, 5'd14, 1,
             32'h0, 0, 4'b1111, 32'h0, 32'h0, 0, 1, 4);
      pulse_end("timeout");

      dmem_ack = 1'b1;
      step();
      step();
      dmem_ack = 1'b0;
      chk("idle ack run_out", 32'(run_out), 32'd0);
      chk("idle ack req", 32'(dmem_req), 32'd0);

      alu_result = 32'h600; re_in = 1'b1; bytes_in = 2'b10; run = 1'b1;
      step();
      drop_in();
      chk("rstmid req", 32'(dmem_req), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rstmid req async", 32'(dmem_req), 32'd0);
      chk("rstmid stall async", 32'(stall_out), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         dmem_ack = (c == 1);
         step();
         seen |= run_out | dmem_req;
      end
      dmem_ack = 1'b0;
      chk("rstmid no run_out", 32'(seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
